vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Display timing generator for the 1024x768 @ 70 Hz VGA mode (75 MHz pixel clock).
//  Sits directly upstream of rojobot_controller and drives its pixel_column, pixel_row
//  and video_on inputs. It also drives the board hsync/vsync pins.
//  Provides frame_start/line_start strobes for the icon/world-map pipeline.
// PARAMETERS
//  H_ACTIVE   1024  visible pixels per line
//  H_FP       24    horizontal front porch (clocks)
//  H_SYNC     136   horizontal sync width (clocks)
//  H_BP       144   horizontal back porch (clocks); H_TOTAL = 1328
//  V_ACTIVE   768   visible lines per frame
//  V_FP       3     vertical front porch (lines)
//  V_SYNC     6     vertical sync width (lines)
//  V_BP       29    vertical back porch (lines); V_TOTAL = 806
//  SYNC_POL   1'b0  active level of hsync/vsync (0 = negative polarity)
//  CW         12    width of pixel_column/pixel_row
// PORTS
//  clk           in   1   pixel clock (the 75 MHz clk_75 domain); one clock only
//  rstn          in   1   reset, asynchronous assert, active-low
//  pixel_column  out  CW  horizontal count 0..H_TOTAL-1
//  pixel_row     out  CW  vertical count 0..V_TOTAL-1
//  video_on      out  1   high only while column<H_ACTIVE and row<V_ACTIVE
//  hsync         out  1   horizontal sync, level SYNC_POL when asserted
//  vsync         out  1   vertical sync, level SYNC_POL when asserted
//  line_start    out  1   one-clock pulse when pixel_column==0
//  frame_start   out  1   one-clock pulse when pixel_column==0 and pixel_row==0
// BEHAVIOUR
//  - Internal h_cnt/v_cnt count freely, with no enable input.
//  - h_cnt wraps H_TOTAL-1 -> 0. v_cnt increments only on that wrap.
//    v_cnt wraps V_TOTAL-1 -> 0 on the same clock as the h_cnt wrap.
//  - All outputs are registered: the outputs at edge n reflect the counter value before edge n.
//    This gives 1-clock latency, so pixel_column/row, video_on, syncs and strobes are mutually aligned.
//  - hsync asserted for H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC, i.e. 1048..1183.
//  - vsync asserted for V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC, i.e. 771..776.
//    vsync follows the row value, changing at the col 0 boundary.
//  - pixel_column/row are not blanked outside the active area. Consumers gate with video_on.
//  - Reset (rstn low, asynchronous):
//    * counters = 0
//    * pixel_column = 0, pixel_row = 0
//    * video_on, line_start, frame_start = 0
//    * hsync = vsync = ~SYNC_POL (deasserted)
//  - First clock after reset release: outputs show col 0 / row 0 with video_on=1,
//    line_start=1 and frame_start=1. A reset mid-frame restarts the frame cleanly at (0,0).
//  - Frame period = H_TOTAL*V_TOTAL = 1,070,368 clocks. Line period = 1328 clocks.
//  - Widths: comparisons are unsigned against CW-bit constants. The parameters must satisfy
//    H_TOTAL, V_TOTAL <= 2**CW; this is elaboration-checked with $error.
// STRUCTURE
//  - Package vga_timing_pkg: H_/V_ timing constants for 1024x768@70 and the derived
//    H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END. Also typedef logic [11:0] vga_coord_t.
//  - Sub-module: none. The two counters plus one output register stage are
//    written inline, in one always_ff block with asynchronous negedge rstn.
// TESTING
//  1. Reset: hold rstn=0 for 5 clocks -> all outputs at reset values, hsync=vsync=1.
//     Release -> next edge gives col 0, row 0, video_on=1, frame_start=1.
//  2. Horizontal sweep: watch one line -> video_on falls at col 1024, hsync=0 exactly for cols 1048..1183.
//     Col wraps from 1327 to 0 with row +1 and line_start=1.
//  3. Vertical: run to row 767 col 1023 -> video_on=1. At row 768 -> video_on=0 for the entire line.
//     vsync=0 exactly for rows 771..776. Row wraps from 805 to 0.
//  4. Frame period: measure between frame_start pulses -> 1,070,368 clocks.
//     line_start count per frame = 806; video_on-high count per frame = 786,432.
//  5. Mid-frame reset: assert rstn=0 asynchronously at row 400 col 600, mid-clock ->
//     outputs go to reset values immediately, without waiting for an edge.
//     After release the sequence restarts at (0,0) identically to scenario 1.
//  6. Integration: connect to rojobot_controller via rojo_if -> its pixel_column/row
//     sweep 0..1023 x 0..767 with video_on matching the bench's previous handcrafted stimulus.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Timing constants for the 1024x768 @ 70 Hz VGA mode (75 MHz pixel clock)
//   and the derived totals / sync window bounds used by vga_timing_gen.
//   Sync windows are half-open: [HS_START, HS_END) and [VS_START, VS_END).
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 144;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 1328
    localparam int HS_START = H_ACTIVE + H_FP;                   // 1048
    localparam int HS_END   = HS_START + H_SYNC;                 // 1184

    // Vertical timing, in lines
    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 806
    localparam int VS_START = V_ACTIVE + V_FP;                   // 771
    localparam int VS_END   = VS_START + V_SYNC;                 // 777

    // Sync polarity (0 = active-low pulses) and coordinate width
    localparam logic SYNC_POL = 1'b0;
    localparam int   CW       = 12;

    typedef logic [11:0] vga_coord_t;

endpackage : vga_timing_pkg

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Free-running display timing generator. Two counters (h_cnt, v_cnt) sweep
//   the full raster; every output is registered from the counter values held
//   before the edge, so coordinates, video_on, syncs and strobes are aligned
//   with one clock of latency.
//
// Ports
//   clk           in   pixel clock (single clock domain)
//   rstn          in   asynchronous active-low reset
//   pixel_column  out  horizontal position 0..H_TOTAL-1 (not blanked)
//   pixel_row     out  vertical position 0..V_TOTAL-1 (not blanked)
//   video_on      out  high inside the visible H_ACTIVE x V_ACTIVE area
//   hsync         out  horizontal sync, SYNC_POL when asserted
//   vsync         out  vertical sync, SYNC_POL when asserted
//   line_start    out  one-clock pulse at column 0
//   frame_start   out  one-clock pulse at column 0, row 0
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_timing_pkg::H_FP,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BP     = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_timing_pkg::V_FP,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BP     = vga_timing_pkg::V_BP,
    parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL,
    parameter int   CW       = vga_timing_pkg::CW
) (
    input  logic          clk,
    input  logic          rstn,
    output logic [CW-1:0] pixel_column,
    output logic [CW-1:0] pixel_row,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // Counters must be able to hold every position of the raster.
    if (H_TOTAL > 2 ** CW) begin : g_h_width_chk
        $error("vga_timing_gen: H_TOTAL (%0d) does not fit in CW=%0d bits", H_TOTAL, CW);
    end
    if (V_TOTAL > 2 ** CW) begin : g_v_width_chk
        $error("vga_timing_gen: V_TOTAL (%0d) does not fit in CW=%0d bits", V_TOTAL, CW);
    end

    // CW-bit constants so every compare below is unsigned and width-matched.
    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START_C = CW'(HS_START);
    localparam logic [CW-1:0] HS_END_C   = CW'(HS_END);
    localparam logic [CW-1:0] VS_START_C = CW'(VS_START);
    localparam logic [CW-1:0] VS_END_C   = CW'(VS_END);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;

    logic in_active;
    logic in_hsync;
    logic in_vsync;

    always_comb begin
        in_active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        in_hsync  = (h_cnt >= HS_START_C) && (h_cnt < HS_END_C);
        // vsync is decoded from the row alone, so it changes together with
        // the row at the column-0 boundary.
        in_vsync  = (v_cnt >= VS_START_C) && (v_cnt < VS_END_C);
    end

    // NOTE: non-blocking assignments make the output stage sample the
    // counter values from before this edge while the counters advance, which
    // is exactly the one-clock latency all outputs share.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            pixel_column <= '0;
            pixel_row    <= '0;
            video_on     <= 1'b0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            // Raster counters: row advances (and wraps) only on a column wrap.
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end

            // Output register stage
            pixel_column <= h_cnt;
            pixel_row    <= v_cnt;
            video_on     <= in_active;
            hsync        <= in_hsync ? SYNC_POL : ~SYNC_POL;
            vsync        <= in_vsync ? SYNC_POL : ~SYNC_POL;
            line_start   <= (h_cnt == '0);
            frame_start  <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule : vga_timing_gen
